if_fetch_queue: RTL and testbench

// Parametrised successor fetch front-end. Keeps up to MAX_OUTSTANDING icache reads in flight.

---
 rtl/if_fetch_queue_pkg.sv | 16 +
 rtl/ifq_fifo.sv | 67 ++++++
 rtl/if_fetch_queue.sv | 152 +++++++++++++++
 tb/tb_if_fetch_queue.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_queue_pkg.sv
// Shared types for the fetch queue: queue entry layout and PC helpers.
package if_fetch_queue_pkg;

    localparam int IFQ_ENTRY_WD = 65;

    typedef struct packed {
        logic        excp;
        logic [31:0] inst;
        logic [31:0] pc;
    } ifq_entry_t;

    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/ifq_fifo.sv
// Synchronous FIFO with async reset and a synchronous clear.
// Clear wins over push/pop; an empty FIFO presents all-zero read data.
module ifq_fifo
    import if_fetch_queue_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        do_push  = push && !clear;
        do_pop   = pop && !clear && (cnt_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) wr_ptr_d = inc(wr_ptr_q);
            if (do_pop)  rd_ptr_d = inc(rd_ptr_q);
            cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = (cnt_q == '0) ? '0 : mem_q[rd_ptr_q];
    assign count = cnt_q;

endmodule

// File: rtl/if_fetch_queue.sv
// Fetch front-end: credit-limited icache requests, epoch-tagged responses, queue to ID.
// IFQ_PERF_CNT_EN adds saturating stall/drop performance counters.
module if_fetch_queue
    import if_fetch_queue_pkg::*;
#(
    parameter int          DEPTH           = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h1c000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic        fs_to_ds_valid,
    output logic [31:0] fs_to_ds_pc,
    output logic [31:0] fs_to_ds_inst,
    output logic        fs_to_ds_excp,
    input  logic        ds_allowin
`ifdef IFQ_PERF_CNT_EN
    ,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_drop_cnt
`endif
);
    localparam int EPOCH_W = $clog2(MAX_OUTSTANDING) + 1;
    localparam int TAG_W   = 32 + EPOCH_W;
    localparam int QCW     = $clog2(DEPTH + 1);
    localparam int OCW     = $clog2(MAX_OUTSTANDING + 1);

    logic [31:0]        pc_q, pc_d;
    logic [EPOCH_W-1:0] epoch_q, epoch_d;
    logic               halt_q, halt_d;

    logic [TAG_W-1:0]   tag_rdata;
    logic [OCW-1:0]     outstanding;
    logic [31:0]        tag_pc;
    logic [EPOCH_W-1:0] tag_epoch;

    ifq_entry_t         q_wdata, q_rdata;
    logic [QCW-1:0]     q_cnt;
    logic               q_push, q_pop;
    logic               credit, accept, live, adef;

    assign tag_pc    = tag_rdata[TAG_W-1:EPOCH_W];
    assign tag_epoch = tag_rdata[EPOCH_W-1:0];

    always_comb begin
        credit = (int'(outstanding) < MAX_OUTSTANDING)
              && (int'(outstanding) + int'(q_cnt) < DEPTH);
        inst_valid = !reset && !halt_q && !redirect_valid
                  && (pc_q[1:0] == 2'b00) && credit;
        accept = inst_valid && inst_addr_ok;
        live   = inst_data_ok && !redirect_valid && (tag_epoch == epoch_q);
        // Misaligned PC faults without touching the icache.
        adef   = !reset && !redirect_valid && !halt_q && !live
              && (pc_q[1:0] != 2'b00) && (int'(q_cnt) < DEPTH);
        q_push = live || adef;
        q_pop  = fs_to_ds_valid && ds_allowin;

        q_wdata      = '0;
        q_wdata.pc   = live ? tag_pc : pc_q;
        q_wdata.inst = live ? inst_rdata : 32'd0;
        q_wdata.excp = !live;

        pc_d    = pc_q;
        epoch_d = epoch_q;
        halt_d  = halt_q;
        if (redirect_valid) begin
            pc_d    = redirect_pc;
            epoch_d = epoch_q + 1'b1;
            halt_d  = 1'b0;
        end else begin
            if (accept) pc_d   = next_pc(pc_q);
            if (adef)   halt_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            epoch_q <= '0;
            halt_q  <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            epoch_q <= epoch_d;
            halt_q  <= halt_d;
        end
    end

    ifq_fifo #(.WIDTH(TAG_W), .DEPTH(MAX_OUTSTANDING)) u_tag_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (1'b0),
        .push  (accept),
        .wdata ({pc_q, epoch_q}),
        .pop   (inst_data_ok),
        .rdata (tag_rdata),
        .count (outstanding)
    );

    ifq_fifo #(.WIDTH(IFQ_ENTRY_WD), .DEPTH(DEPTH)) u_inst_queue (
        .clk   (clk),
        .reset (reset),
        .clear (redirect_valid),
        .push  (q_push),
        .wdata (q_wdata),
        .pop   (q_pop),
        .rdata (q_rdata),
        .count (q_cnt)
    );

    assign inst_addr      = reset ? 32'd0 : pc_q;
    assign fs_to_ds_valid = (q_cnt != '0);
    assign fs_to_ds_pc    = q_rdata.pc;
    assign fs_to_ds_inst  = q_rdata.inst;
    assign fs_to_ds_excp  = q_rdata.excp;

    a_no_orphan_data: assert property (
        @(posedge clk) disable iff (reset) inst_data_ok |-> (outstanding != '0));

`ifdef IFQ_PERF_CNT_EN
    logic [31:0] stall_q, stall_d, drop_q, drop_d;

    always_comb begin
        stall_d = stall_q;
        drop_d  = drop_q;
        if ((int'(q_cnt) == DEPTH) && !ds_allowin && (stall_q != '1))
            stall_d = stall_q + 32'd1;
        if (inst_data_ok && !live && (drop_q != '1))
            drop_d = drop_q + 32'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
            drop_q  <= '0;
        end else begin
            stall_q <= stall_d;
            drop_q  <= drop_d;
        end
    end

    assign perf_stall_cnt = stall_q;
    assign perf_drop_cnt  = drop_q;
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// Randomised bench for if_fetch_queue against a queue-based reference model.
module tb_if_fetch_queue;

    localparam logic [31:0] RST_PC = 32'h1c000000;

    logic        clk;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        fs_to_ds_valid;
    logic [31:0] fs_to_ds_pc;
    logic [31:0] fs_to_ds_inst;
    logic        fs_to_ds_excp;
    logic        ds_allowin;

    if_fetch_queue #(
        .DEPTH(4),
        .MAX_OUTSTANDING(2),
        .RESET_PC(RST_PC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_addr      (inst_addr),
        .inst_addr_ok   (inst_addr_ok),
        .inst_data_ok   (inst_data_ok),
        .inst_rdata     (inst_rdata),
        .fs_to_ds_valid (fs_to_ds_valid),
        .fs_to_ds_pc    (fs_to_ds_pc),
        .fs_to_ds_inst  (fs_to_ds_inst),
        .fs_to_ds_excp  (fs_to_ds_excp),
        .ds_allowin     (ds_allowin)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        int          ep;
    } tag_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        excp;
    } ent_t;

    tag_t        tags[$];
    ent_t        q[$];
    logic [31:0] m_pc;
    int          m_ep;
    bit          m_halt;
    int          n_cmp;
    int          n_err;

    function automatic logic [31:0] icache_word(input logic [31:0] a);
        return (a * 32'h9e3779b1) ^ 32'h5a5a0001;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc   = RST_PC;
        m_ep   = 0;
        m_halt = 0;
        tags.delete();
        q.delete();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_iv"},   32'(inst_valid),     32'd0);
        chk({tag, "_addr"}, inst_addr,           32'd0);
        chk({tag, "_fsv"},  32'(fs_to_ds_valid), 32'd0);
        chk({tag, "_pc"},   fs_to_ds_pc,         32'd0);
        chk({tag, "_inst"}, fs_to_ds_inst,       32'd0);
        chk({tag, "_excp"}, 32'(fs_to_ds_excp),  32'd0);
    endtask

    // One cycle: drive at posedge+1, compare at posedge+2, advance model.
    task automatic step(input bit rv, input logic [31:0] rpc, input bit aok,
                        input bit dok_req, input bit allow);
        bit   dok;
        bit   exp_iv;
        bit   adef;
        tag_t t;
        dok = dok_req && (tags.size() > 0);
        redirect_valid = rv;
        redirect_pc    = rpc;
        inst_addr_ok   = aok;
        inst_data_ok   = dok;
        inst_rdata     = dok ? icache_word(tags[0].pc) : $urandom;
        ds_allowin     = allow;
        #1;
        exp_iv = !m_halt && !rv && (m_pc[1:0] == 2'b00)
              && (tags.size() < 2) && (tags.size() + q.size() < 4);
        chk("inst_valid", 32'(inst_valid), 32'(exp_iv));
        if (exp_iv) chk("inst_addr", inst_addr, m_pc);
        chk("fs_valid", 32'(fs_to_ds_valid), 32'(q.size() > 0));
        if (q.size() > 0) begin
            chk("fs_pc",   fs_to_ds_pc,        q[0].pc);
            chk("fs_inst", fs_to_ds_inst,      q[0].inst);
            chk("fs_excp", 32'(fs_to_ds_excp), 32'(q[0].excp));
        end
        if (rv) begin
            q.delete();
            if (dok) void'(tags.pop_front());
            m_pc   = rpc;
            m_ep++;
            m_halt = 0;
        end else begin
            adef = (m_pc[1:0] != 2'b00) && !m_halt && (q.size() < 4);
            if ((q.size() > 0) && allow) void'(q.pop_front());
            if (dok) begin
                t = tags.pop_front();
                if (t.ep == m_ep) q.push_back('{t.pc, icache_word(t.pc), 1'b0});
            end
            if (adef) begin
                q.push_back('{m_pc, 32'd0, 1'b1});
                m_halt = 1;
            end
            if (exp_iv && aok) begin
                tags.push_back('{m_pc, m_ep});
                m_pc = m_pc + 32'd4;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic mid_reset();
        redirect_valid = 1'b0;
        inst_addr_ok   = 1'b0;
        inst_data_ok   = 1'b0;
        ds_allowin     = 1'b1;
        reset          = 1'b1;
        #1;
        chk_all_zero("mid_rst");
        model_reset();
        @(posedge clk);
        #1;
        chk("mid_rst_hold_iv", 32'(inst_valid), 32'd0);
        reset = 1'b0;
    endtask

    initial begin
        logic [31:0] r;
        bit          rv;
        n_cmp = 0;
        n_err = 0;
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        inst_addr_ok   = 1'b0;
        inst_data_ok   = 1'b0;
        inst_rdata     = 32'd0;
        ds_allowin     = 1'b0;
        model_reset();
        #1;
        chk_all_zero("rst");
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Streaming fetch, then ID stall fills the queue.
        for (int i = 0; i < 12; i++) step(0, 32'd0, 1, 1, 1);
        for (int i = 0; i < 10; i++) step(0, 32'd0, 1, 1, 0);
        chk("full_no_req", 32'(inst_valid), 32'd0);
        chk("full_count", 32'(q.size()), 32'd4);
        // Drain, leave two requests in flight, then redirect over them.
        for (int i = 0; i < 6; i++) step(0, 32'd0, 1, 0, 1);
        step(1, 32'h1c001000, 1, 0, 1);
        for (int i = 0; i < 2; i++) step(0, 32'd0, 0, 1, 1);
        for (int i = 0; i < 6; i++) step(0, 32'd0, 1, 1, 1);
        // Misaligned redirect faults, then a clean redirect resumes.
        step(1, 32'h1c000002, 1, 1, 0);
        for (int i = 0; i < 4; i++) step(0, 32'd0, 1, 1, 0);
        step(1, 32'h1c000100, 1, 1, 1);
        for (int i = 0; i < 6; i++) step(0, 32'd0, 1, 0, 0);
        // Redirect together with data_ok and a head pop.
        step(1, 32'h1c000200, 1, 1, 1);
        chk("redir_pop_empty", 32'(fs_to_ds_valid), 32'd0);
        for (int i = 0; i < 4; i++) step(0, 32'd0, 1, 0, 1);
        mid_reset();

        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) mid_reset();
            r = 32'h1c000000 + 32'($urandom_range(0, 255)) * 32'd4;
            if ($urandom_range(0, 7) == 0) r[1:0] = 2'($urandom_range(1, 3));
            // Skip redirects that would let a 2-bit epoch alias an in-flight tag.
            rv = ($urandom_range(0, m_halt ? 3 : 12) == 0)
              && ((tags.size() == 0) || (m_ep - tags[0].ep < 3));
            step(rv, r, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 3) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
